// File: rtl/fetch_pkg.sv
// Shared fetch front-end constants and the fetch-entry payload type.
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned PC_STEP  = 4;

  // Canonical RISC-V nop (addi x0, x0, 0)
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  // One fetched instruction tagged with its PC
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between instruction memory responses and decode.
// flush has priority over push; head shows the oldest entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  input  logic                      flush,
  output logic [$clog2(QDEPTH):0]   count,
  output logic [WIDTH-1:0]          head
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle
  assign do_push = push && ((count < CW'(QDEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, no reset needed since count qualifies every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation with redirect, imem request
// gating against queue space, stale-response dropping and a fetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_inst_o,
  input  logic            id_ready_i
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            push;
  logic            accept;
  entry_t          head;
  entry_t          wentry;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign pop        = id_valid_o && id_ready_i;
  assign id_valid_o = (count != '0);

  // Queue slots already spoken for, counting the outstanding response and this cycle's pop
  assign occupancy  = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_req_o = !rst && !redirect_i && (occupancy < (CW+1)'(QDEPTH));
  assign accept     = imem_req_o && imem_gnt_i;
  assign imem_addr_o = pc;

  // Only a live, non-stale response outside a redirect cycle lands in the queue
  assign push   = imem_rvalid_i && inflight && !drop && !redirect_i && !rst;
  assign wentry = '{pc: resp_pc, inst: imem_rdata_i};

  // PC, inflight and drop tracking; redirect outranks everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else if (redirect_i) begin
      pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      if (inflight && !imem_rvalid_i) begin
        inflight <= 1'b1;
        drop     <= 1'b1;
      end else begin
        inflight <= 1'b0;
        drop     <= 1'b0;
      end
    end else begin
      if (accept) begin
        pc       <= pc + XLEN'(PC_STEP);
        inflight <= 1'b1;
      end else if (imem_rvalid_i) begin
        inflight <= 1'b0;
      end
      if (imem_rvalid_i && inflight) drop <= 1'b0;
    end
  end

  // Address of the outstanding request, paired with its response on return
  always_ff @(posedge clk) begin
    if (!rst && !redirect_i && accept) resp_pc <= pc;
  end

  fetch_queue #(
    .WIDTH  (EW),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect_i),
    .count (count),
    .head  (head)
  );

  // Present a nop when nothing is queued so decode never sees stale bits
  assign id_pc_o   = head.pc;
  assign id_inst_o = id_valid_o ? head.inst : INST_NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model checked
// every cycle, plus hand-computed expectations on reset, latency,
// back-pressure, redirect and PC wrap.
module tb_fetch_unit;

  localparam int unsigned QD   = 2;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] WPC  = 32'hFFFF_FFF8;
  localparam logic [31:0] XORV = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ready;
  logic        req;
  logic [31:0] addr;
  logic        vld;
  logic [31:0] idpc;
  logic [31:0] idinst;

  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_vld;
  logic [31:0] w_idpc;
  logic [31:0] w_idinst;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .id_valid_o(vld), .id_pc_o(idpc), .id_inst_o(idinst), .id_ready_i(ready)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(WPC), .QDEPTH(QD)) dut_wrap (
    .clk(clk), .rst(rst), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .id_valid_o(w_vld), .id_pc_o(w_idpc), .id_inst_o(w_idinst), .id_ready_i(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  ent_t        mq[$];
  bit          mpend;
  bit          mdrop;
  logic [31:0] mpc;
  logic [31:0] mresp;
  bit          mem_pend;
  logic [31:0] mem_addr;
  bit          w_pend;
  logic [31:0] w_pc;
  logic [31:0] w_resp;

  // per-cycle snapshots for the hand-computed checks
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_inst;
  logic [31:0] ws_addr, ws_pc;
  logic        ws_vld;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Drive one cycle, check DUT against the model mid-cycle, then advance the model
  task automatic cyc(input bit r, input bit rdy, input bit g, input bit rd, input logic [31:0] rpc);
    bit pop;
    bit ereq;
    int occ;
    rst = r; ready = rdy; gnt = g; redirect = rd; redirect_pc = rpc;
    rvalid = mem_pend; rdata = mem_addr ^ XORV;
    w_rvalid = w_pend; w_rdata = w_resp ^ XORV;
    @(negedge clk);
    s_req = req; s_vld = vld; s_addr = addr; s_pc = idpc; s_inst = idinst;
    ws_addr = w_addr; ws_pc = w_idpc; ws_vld = w_vld;

    pop  = (mq.size() != 0) && rdy;
    occ  = mq.size() + int'(mpend) - int'(pop);
    ereq = !r && !rd && (occ < int'(QD));
    chk("imem_req", req, ereq);
    if (!r) begin
      chk("imem_addr", addr, mpc);
      chk("id_valid", vld, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("id_pc", idpc, mq[0].pc);
        chk("id_inst", idinst, mq[0].inst);
      end
      chk("wrap_addr", w_addr, w_pc);
    end

    mem_pend = 1'b0;
    if (r) begin
      mq.delete(); mpend = 1'b0; mdrop = 1'b0; mpc = RPC;
    end else if (rd) begin
      mq.delete();
      mdrop = mpend && !rvalid;
      mpend = mdrop;
      mpc   = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (rvalid && mpend) begin
        if (!mdrop) begin
          chk("queue_not_full_on_push", mq.size() < int'(QD), 1'b1);
          mq.push_back('{pc: mresp, inst: rdata});
        end
        mpend = 1'b0; mdrop = 1'b0;
      end
      if (ereq && g) begin
        mresp = mpc; mpend = 1'b1; mem_pend = 1'b1; mem_addr = mpc; mpc = mpc + 32'd4;
      end
    end

    w_pend = 1'b0;
    if (r) w_pc = WPC;
    else begin
      w_pend = 1'b1; w_resp = w_pc; w_pc = w_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; gnt = 1'b1; redirect = 1'b0; redirect_pc = '0;
    rvalid = 1'b0; rdata = '0; w_rvalid = 1'b0; w_rdata = '0;
    mpend = 0; mdrop = 0; mpc = RPC; mresp = '0; mem_pend = 0; mem_addr = '0;
    w_pend = 0; w_pc = WPC; w_resp = '0;
    @(posedge clk); #1;

    // reset
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, 0);
      chk("rst_valid", s_vld, 1'b0);
      chk("rst_req", s_req, 1'b0);
      chk("rst_addr", s_addr, 32'h100);
      chk("rst_wrap_addr", ws_addr, 32'hFFFF_FFF8);
    end

    // reset release and first-fetch latency
    cyc(0, 1, 1, 0, 0);
    chk("c0_req", s_req, 1'b1);
    chk("c0_addr", s_addr, 32'h100);
    chk("c0_valid", s_vld, 1'b0);
    chk("c0_wrap_addr", ws_addr, 32'hFFFF_FFF8);
    cyc(0, 1, 1, 0, 0);
    chk("c1_addr", s_addr, 32'h104);
    chk("c1_valid", s_vld, 1'b0);
    chk("c1_wrap_addr", ws_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, 0);
    chk("c2_valid", s_vld, 1'b1);
    chk("c2_pc", s_pc, 32'h100);
    chk("c2_inst", s_inst, 32'hA5A5_0100);
    chk("c2_wrap_addr", ws_addr, 32'h0000_0000);
    chk("c2_wrap_pc", ws_pc, 32'hFFFF_FFF8);
    cyc(0, 1, 1, 0, 0);
    chk("c3_pc", s_pc, 32'h104);
    chk("c3_wrap_pc", ws_pc, 32'hFFFF_FFFC);

    // back-pressure: queue fills, requests stop, head holds
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("bp_head", s_pc, 32'h108);
      chk("bp_req", s_req, 1'b0);
      chk("bp_valid", s_vld, 1'b1);
    end
    chk("c8_wrap_pc", ws_pc, 32'h0000_0010);
    cyc(0, 1, 1, 0, 0);
    chk("rel_pc", s_pc, 32'h108);
    chk("rel_req", s_req, 1'b1);
    chk("rel_addr", s_addr, 32'h110);
    cyc(0, 1, 1, 0, 0);
    chk("rel1_pc", s_pc, 32'h10C);
    cyc(0, 1, 1, 0, 0);
    chk("rel2_pc", s_pc, 32'h110);

    // redirect with a response returning and a pop in the same cycle
    cyc(0, 1, 1, 1, 32'h2002);
    chk("rd_req", s_req, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("rd1_addr", s_addr, 32'h2000);
    chk("rd1_req", s_req, 1'b1);
    chk("rd1_valid", s_vld, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("rd2_valid", s_vld, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("rd3_valid", s_vld, 1'b1);
    chk("rd3_pc", s_pc, 32'h2000);
    chk("rd3_inst", s_inst, 32'hA5A5_2000);
    cyc(0, 1, 1, 0, 0);
    chk("rd4_pc", s_pc, 32'h2004);

    // redirect into a full, stalled queue, then back-to-back redirects
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h3001);
    cyc(0, 1, 0, 0, 0);
    chk("gnt0_addr", s_addr, 32'h3000);
    cyc(0, 1, 0, 0, 0);
    chk("gnt0_hold", s_addr, 32'h3000);
    cyc(0, 1, 1, 1, 32'h4000);
    cyc(0, 1, 1, 1, 32'h5004);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);

    // random grant / ready / occasional redirect
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) == 0, $urandom & 32'h0000_FFFF);
    end

    // reset mid-stream, colliding with a redirect
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 32'h7000);
    chk("mrst_req", s_req, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("mrst_addr", s_addr, 32'h100);
    chk("mrst_valid", s_vld, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("mrst1_valid", s_vld, 1'b0);
    cyc(0, 1, 1, 0, 0);
    chk("mrst2_valid", s_vld, 1'b1);
    chk("mrst2_pc", s_pc, 32'h100);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
